fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_pc_gen.sv | 39 +++
 rtl/fetch_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared front-end constants and helpers, reused by fetch, decode and
// immediate generation.
package fetch_stage_pkg;

   localparam int unsigned     PC_W         = 32;
   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_2000;
   localparam logic [31:0]     NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      SEL_RESET    = 2'd0,
      SEL_REDIRECT = 2'd1,
      SEL_HOLD     = 2'd2,
      SEL_SEQ      = 2'd3
   } pc_sel_e;

   // Misaligned redirect targets are silently word-aligned, never trapped.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// Combinational next-PC selection for the fetch stage.
// Priority: reset, then redirect, then stall, else sequential +4.
module fetch_pc_gen
   import fetch_stage_pkg::*;
(
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic [PC_W-1:0] reset_pc,
   input  logic [PC_W-1:0] pc_f,
   output logic [PC_W-1:0] pc_next
);

   pc_sel_e sel_s;

   // Choose the next-PC source and form the next fetch address.
   always_comb begin
      sel_s   = SEL_SEQ;
      pc_next = pc_f;
      if (reset) begin
         sel_s = SEL_RESET;
      end else if (redirect_valid) begin
         sel_s = SEL_REDIRECT;
      end else if (stall) begin
         sel_s = SEL_HOLD;
      end else begin
         sel_s = SEL_SEQ;
      end
      case (sel_s)
         SEL_RESET:    pc_next = reset_pc;
         SEL_REDIRECT: pc_next = align_pc(redirect_pc);
         SEL_HOLD:     pc_next = pc_f;
         SEL_SEQ:      pc_next = pc_f + 32'd4;
         default:      pc_next = reset_pc;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage in front of a 1-cycle synchronous IMEM: PC
// registers, a one-entry hold buffer for stalls, and redirect flushing.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_dout,
   output logic [31:0]     inst,
   output logic [PC_W-1:0] inst_pc,
   output logic            inst_valid
);

   logic [PC_W-1:0] pc_f_r;
   logic [PC_W-1:0] pc_d_r;
   logic [PC_W-1:0] pc_next_s;
   logic            valid_r;
   logic            hold_r;
   logic [31:0]     hold_inst_r;
   logic [31:0]     inst_raw_s;
   logic            inst_valid_s;

   fetch_pc_gen u_pc_gen (
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .reset_pc       (RESET_PC),
      .pc_f           (pc_f_r),
      .pc_next        (pc_next_s)
   );

   // Decode-side instruction mux; a redirect kills the slot in the same cycle.
   always_comb begin
      inst_valid_s = valid_r & ~redirect_valid;
      if (hold_r) begin
         inst_raw_s = hold_inst_r;
      end else begin
         inst_raw_s = imem_dout;
      end
      if (inst_valid_s) begin
         inst = inst_raw_s;
      end else begin
         inst = NOP_INST;
      end
   end

   assign imem_addr  = pc_f_r;
   assign inst_pc    = pc_d_r;
   assign inst_valid = inst_valid_s;

   // PC, valid and hold-buffer state update.
   always_ff @(posedge clk) begin
      pc_f_r <= pc_next_s;
      if (reset) begin
         pc_d_r      <= 32'h0000_0000;
         valid_r     <= 1'b0;
         hold_r      <= 1'b0;
         hold_inst_r <= 32'h0000_0000;
      end else if (redirect_valid) begin
         valid_r <= 1'b0;
         hold_r  <= 1'b0;
      end else if (stall) begin
         // IMEM output moves on once the address stops advancing, so latch it once.
         if (!hold_r) begin
            hold_inst_r <= imem_dout;
            hold_r      <= 1'b1;
         end else begin
            hold_r <= 1'b1;
         end
      end else begin
         pc_d_r  <= pc_f_r;
         valid_r <= 1'b1;
         hold_r  <= 1'b0;
      end
   end

endmodule
